// File: rtl/skinny_sbox_sweep_checker.sv
// Exhaustive S-box sweep checker: drives every input to a golden LUT and a DUT,
// aligns the LUT result with the DUT latency and counts mismatches.
// Ports: clk, rst (sync, active-high), start | si/si_valid stimulus out,
//   so_ref/so_dut results in | busy, done, pass, err_count, first_err_in/_valid.
module skinny_sbox_sweep_checker #(
  parameter int W           = 8,
  parameter int LAT         = 0,
  parameter int STOP_ON_ERR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] si,
  output logic         si_valid,
  input  logic [W-1:0] so_ref,
  input  logic [W-1:0] so_dut,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W:0]   err_count,
  output logic [W-1:0] first_err_in,
  output logic         first_err_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DRN_INIT =
    (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t       state_q, state_d;
  logic [W-1:0] si_q, si_d;
  logic         siv_q, siv_d;
  logic [W:0]   err_q, err_d;
  logic [W-1:0] fei_q, fei_d;
  logic         fev_q, fev_d;
  logic [2:0]   drn_q, drn_d;
  logic         busy_q, done_q, pass_q;
  logic         busy_d, done_d, pass_d;

  // Delayed copies of the stimulus tag, value and golden result.
  logic         dv;
  logic [W-1:0] din;
  logic [W-1:0] dref;
  logic         mism;
  logic         stop;

  assign mism = dv && (so_dut != dref);
  assign stop = (STOP_ON_ERR != 0) && mism;

  generate
    if (LAT == 0) begin : g_nodly
      assign dv   = siv_q;
      assign din  = si_q;
      assign dref = so_ref;
    end else begin : g_dly
      logic [LAT-1:0] vld_q;
      logic [W-1:0]   in_q  [LAT];
      logic [W-1:0]   ref_q [LAT];

      // An early stop discards everything still in flight.
      always_ff @(posedge clk) begin
        if (rst || stop) begin
          for (int i = 0; i < LAT; i++) begin
            vld_q[i] <= 1'b0;
            in_q[i]  <= '0;
            ref_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= siv_q;
          in_q[0]  <= si_q;
          ref_q[0] <= so_ref;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            in_q[i]  <= in_q[i-1];
            ref_q[i] <= ref_q[i-1];
          end
        end
      end

      assign dv   = vld_q[LAT-1];
      assign din  = in_q[LAT-1];
      assign dref = ref_q[LAT-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    si_d    = si_q;
    siv_d   = siv_q;
    err_d   = err_q;
    fei_d   = fei_q;
    fev_d   = fev_q;
    drn_d   = drn_q;

    if (mism) begin
      err_d = err_q + 1'b1;
      if (!fev_q) begin
        fei_d = din;
        fev_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          si_d    = '0;
          siv_d   = 1'b1;
          err_d   = '0;
          fei_d   = '0;
          fev_d   = 1'b0;
        end
      end
      SWEEP: begin
        if (stop) begin
          state_d = DONE;
          si_d    = '0;
          siv_d   = 1'b0;
        end else if (si_q == '1) begin
          si_d    = '0;
          siv_d   = 1'b0;
          drn_d   = DRN_INIT;
          state_d = (LAT == 0) ? DONE : DRAIN;
        end else begin
          si_d = si_q + 1'b1;
        end
      end
      DRAIN: begin
        if (stop || drn_q == 3'd0) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SWEEP) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      si_q    <= '0;
      siv_q   <= 1'b0;
      err_q   <= '0;
      fei_q   <= '0;
      fev_q   <= 1'b0;
      drn_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      si_q    <= si_d;
      siv_q   <= siv_d;
      err_q   <= err_d;
      fei_q   <= fei_d;
      fev_q   <= fev_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign si              = si_q;
  assign si_valid        = siv_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_in    = fei_q;
  assign first_err_valid = fev_q;

endmodule

// File: doc/skinny_sbox_sweep_checker.md
SKINNY_SBOX_SWEEP_CHECKER -- requirements
Module: skinny_sbox_sweep_checker

Interface
REQ-001 Parameter W, default 8: S-box width in bits; legal values 4 and 8.
REQ-002 Parameter LAT, default 0: DUT S-box latency in clock cycles; legal range 0..7.
REQ-003 Parameter STOP_ON_ERR, default 0: when 1, the sweep ends at the first mismatch.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin a sweep.
REQ-007 si  output  W  S-box input driven to both the golden LUT and the DUT.
REQ-008 si_valid  output  1  si carries a sweep stimulus this cycle.
REQ-009 so_ref  input  W  golden LUT output, combinational in si.
REQ-010 so_dut  input  W  DUT output; for stimulus si it arrives LAT cycles later.
REQ-011 busy  output  1  sweep in progress.
REQ-012 done  output  1  sweep finished; held until the next accepted start or rst.
REQ-013 pass  output  1  high only when done=1 and err_count=0.
REQ-014 err_count  output  W+1  number of mismatches in the last sweep.
REQ-015 first_err_in  output  W  stimulus value of the first mismatch.
REQ-016 first_err_valid  output  1  first_err_in holds a captured value.

Function
REQ-017 FSM states SHALL be IDLE, SWEEP, DRAIN and DONE.
REQ-018 start SHALL be accepted only in IDLE or DONE; start in SWEEP or DRAIN SHALL be ignored.
REQ-019 On an accepting edge k: state -> SWEEP; err_count, first_err_in, first_err_valid, done and pass cleared; si=0 and si_valid=1 during cycle k.
REQ-020 In SWEEP, si SHALL increment by 1 each cycle, so si=j during cycle k+j for j = 0..2^W-1.
REQ-021 After si=2^W-1 is issued: state -> DRAIN when LAT>0, or -> DONE when LAT=0; si_valid=0 and si=0 outside SWEEP.
REQ-022 so_ref and the stimulus value SHALL each pass through an internal LAT-stage delay line (LAT=0: no delay) so they align with so_dut.
REQ-023 The compare for stimulus j SHALL be evaluated in cycle k+j+LAT and registered at edge k+j+LAT+1.
REQ-024 On a mismatch, err_count SHALL increment by 1; err_count is W+1 bits, so 2^W mismatches cannot overflow it.
REQ-025 On the first mismatch of a sweep, first_err_in <= j and first_err_valid <= 1; later mismatches SHALL NOT change them.
REQ-026 DRAIN SHALL last exactly LAT cycles; DONE SHALL be entered at edge k+2^W+LAT, the same edge that registers the final compare.
REQ-027 busy=1 in SWEEP and DRAIN, else 0.
REQ-028 done=1 only in DONE; pass = done AND (err_count==0).
REQ-029 STOP_ON_ERR=1: the edge that registers the first mismatch SHALL also move the state to DONE; in-flight delay-line entries are discarded and err_count=1.
REQ-030 Compares SHALL be gated by the delayed si_valid tag; so_dut SHALL be ignored in cycles with no valid tag.

Reset
REQ-031 With rst=1 at an edge, the block SHALL enter IDLE with all outputs 0 and both delay lines cleared.
REQ-032 rst SHALL take priority over start and over any in-progress sweep, including mid-SWEEP and mid-DRAIN.
REQ-033 After reset the block SHALL accept start on the first edge at which rst=0.

Verification
REQ-034 W=8, LAT=0, so_dut=so_ref, start pulse -> si sweeps 0x00..0xFF; done exactly 256 cycles after the start edge; err_count=0; pass=1; first_err_valid=0.
REQ-035 W=8, LAT=3, DUT model = LUT delayed 3 cycles -> done at start+259; pass=1; busy high for 259 cycles.
REQ-036 W=8, LAT=2, DUT faulted at inputs 0x2A and 0x80 -> err_count=2, first_err_in=0x2A, pass=0.
REQ-037 Same fault, STOP_ON_ERR=1 -> done at start edge + 0x2A + 3 (45 cycles); err_count=1; first_err_in=0x2A.
REQ-038 W=4, LAT=0, start re-pulsed during SWEEP, then rst at cycle 10 -> re-pulse ignored; after reset all outputs 0 and state IDLE; a new start gives done 16 cycles later with pass=1.
REQ-039 W=4, LAT=1, DUT output inverted for every input -> err_count=16 (0x10, no overflow); first_err_in=0x0.
